// File: rtl/core_defs_pkg.sv
// Shared core definitions: datapath widths and the write-port arbiter state type.
package core_defs_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/wb_wport_arb.sv
// Register-file write-port arbiter: the in-order pipeline normally wins,
// the MDU gets a forced slot after STARVE_MAX consecutive denials, and a
// same-destination collision drops the older MDU result.
module wb_wport_arb
  import core_defs_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid_i,
  input  logic [XLEN-1:0]       pipe_op_c_i,
  input  logic [REG_ADDR_W-1:0] pipe_reg_waddr_i,
  output logic                  pipe_stall_o,
  input  logic                  mdu_valid_i,
  input  logic [XLEN-1:0]       mdu_data_i,
  input  logic [REG_ADDR_W-1:0] mdu_waddr_i,
  output logic                  mdu_ready_o,
  output logic                  wb_we_o,
  output logic [XLEN-1:0]       wb_op_c_o,
  output logic [REG_ADDR_W-1:0] wb_reg_waddr_o
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  wb_arb_state_e state, state_next;
  logic [3:0]    starve_cnt, starve_cnt_next;
  logic          pipe_need, mdu_need, force_grant;
  logic          grant_pipe, grant_mdu, mdu_denied;

  // Grant selection, handshake outputs and starvation bookkeeping for this cycle.
  always_comb begin
    pipe_need       = pipe_valid_i && (pipe_reg_waddr_i != '0);
    mdu_need        = mdu_valid_i && (mdu_waddr_i != '0);
    force_grant     = (state == FORCE) && mdu_need;
    grant_pipe      = 1'b0;
    grant_mdu       = 1'b0;
    mdu_denied      = 1'b0;
    mdu_ready_o     = 1'b0;
    pipe_stall_o    = 1'b0;
    state_next      = NORMAL;
    starve_cnt_next = '0;

    if (force_grant) begin
      // MDU goes first even on a same-address clash; the stalled pipe write follows.
      grant_mdu    = 1'b1;
      mdu_ready_o  = 1'b1;
      pipe_stall_o = pipe_need;
    end else if (pipe_need) begin
      grant_pipe = 1'b1;
      if (mdu_need) begin
        if (mdu_waddr_i == pipe_reg_waddr_i) begin
          mdu_ready_o = 1'b1;
        end else begin
          mdu_denied = 1'b1;
        end
      end else begin
        mdu_ready_o = mdu_valid_i;
      end
    end else begin
      mdu_ready_o = mdu_valid_i;
      grant_mdu   = mdu_need;
    end

    if (mdu_denied) begin
      starve_cnt_next = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      if (starve_cnt_next >= STARVE_LIMIT) begin
        state_next = FORCE;
      end
    end

    if (rst) begin
      mdu_ready_o  = 1'b0;
      pipe_stall_o = 1'b0;
      grant_pipe   = 1'b0;
      grant_mdu    = 1'b0;
    end
  end

  // Arbiter state and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Registered write port; data and address hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_o        <= 1'b0;
      wb_op_c_o      <= '0;
      wb_reg_waddr_o <= '0;
    end else begin
      wb_we_o <= grant_pipe || grant_mdu;
      if (grant_mdu) begin
        wb_op_c_o      <= mdu_data_i;
        wb_reg_waddr_o <= mdu_waddr_i;
      end else if (grant_pipe) begin
        wb_op_c_o      <= pipe_op_c_i;
        wb_reg_waddr_o <= pipe_reg_waddr_i;
      end
    end
  end

endmodule
